// File: rtl/jogo_seq_pkg.sv
// Shared definitions for the memory-sequence game core.
//   - FSM state codes (visible on db_estado, so the numeric values matter)
//   - DB_ESTADO_W: width of the db_estado debug port
//   - clog2(): width helper used to size counters and RAM addresses
package jogo_seq_pkg;

  localparam int DB_ESTADO_W = 4;

  typedef logic [DB_ESTADO_W-1:0] estado_t;

  localparam estado_t INICIAL       = 4'h0;
  localparam estado_t PREPARA       = 4'h1;
  localparam estado_t ESPERA_JOGADA = 4'h2;
  localparam estado_t MOSTRA        = 4'h3;
  localparam estado_t ESPERA_NOVA   = 4'h4;
  localparam estado_t COMPARA       = 4'h5;
  localparam estado_t PROX_JOGADA   = 4'h6;
  localparam estado_t PROX_RODADA   = 4'h7;
  localparam estado_t GRAVA         = 4'h8;
  localparam estado_t ACERTOU       = 4'h9;
  localparam estado_t ERROU         = 4'hA;
  localparam estado_t TIMEOUT       = 4'hB;

  // Ceiling log2, never less than 1 so it can always size a vector.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/jogo_seq_ram.sv
// Play memory for the sequence game: DEPTH entries of WIDTH bits.
// Synchronous write, asynchronous read, no reset (contents are always
// written before they are read).
// Ports:
//   clock  in   1      system clock
//   we     in   1      write enable
//   waddr  in   AW     write address
//   wdata  in   WIDTH  write data
//   raddr  in   AW     read address
//   rdata  out  WIDTH  read data (combinational)
module jogo_seq_ram import jogo_seq_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jogo_sequencia_param.sv
// Parametrised "memory sequence" game core. In round r the player repeats
// the stored plays 0..r-1 and then enters a new play r, which is stored.
// The game is won after PROF plays are stored and lost on a wrong play,
// a multi-button press or an inactivity timeout.
//
// Optional feature macro: JOGO_SEQ_SHOW_SEQ_EN
//   defined   -> MOSTRA state replays ram[0..r-1] on the LEDs before every
//                repeat phase (ESPERA_LED cycles on, ESPERA_LED cycles off)
//   undefined -> no playback; the player works from memory
//
// Ports:
//   clock       in   1          system clock
//   reset       in   1          synchronous, active-high
//   jogar       in   1          start/restart request (level)
//   botoes      in   N_BOTOES   debounced buttons, synchronous to clock
//   leds        out  N_BOTOES   button echo / sequence playback
//   ganhou      out  1          won
//   perdeu      out  1          lost (error or timeout)
//   pronto      out  1          any final state
//   db_timeout  out  1          lost by timeout
//   db_estado   out  4          FSM state code
//   db_rodada   out  AW+1       current round r (0..PROF)
//   db_jogada   out  AW         current play index j
module jogo_sequencia_param import jogo_seq_pkg::*; #(
  parameter  int N_BOTOES       = 4,
  parameter  int PROF           = 16,
  parameter  int TIMEOUT_CICLOS = 5000,
  parameter  int ESPERA_LED     = 500,
  localparam int AW             = clog2(PROF)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   jogar,
  input  logic [N_BOTOES-1:0]    botoes,
  output logic [N_BOTOES-1:0]    leds,
  output logic                   ganhou,
  output logic                   perdeu,
  output logic                   pronto,
  output logic                   db_timeout,
  output logic [DB_ESTADO_W-1:0] db_estado,
  output logic [AW:0]            db_rodada,
  output logic [AW-1:0]          db_jogada
);

  // One counter serves as idle timer in the wait states and as step timer
  // during playback, so it is sized for the longer of the two intervals.
  localparam int CNT_MAX = (TIMEOUT_CICLOS > ESPERA_LED) ? TIMEOUT_CICLOS : ESPERA_LED;
  localparam int TW      = clog2(CNT_MAX + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CICLOS - 1);

  estado_t state, next;

  logic [N_BOTOES-1:0] botoes_reg;
  logic [N_BOTOES-1:0] cap;
  logic                any_prev;
  logic                play_ev;
  logic                cap_ok;

  logic [AW:0]   r;
  logic [AW-1:0] j;
  logic          j_last;
  logic          r_last;

  logic [TW-1:0] cnt;
  logic          wait_st;
  logic          tmo_exp;

  logic                ram_we;
  logic [AW-1:0]       ram_raddr;
  logic [N_BOTOES-1:0] ram_rdata;

  assign play_ev = (|botoes_reg) & ~any_prev;
  // A valid play has exactly one button set.
  assign cap_ok  = (cap != '0) && ((cap & (cap - N_BOTOES'(1))) == '0);
  assign j_last  = ({1'b0, j} == (r - 1'b1));
  assign r_last  = (r == (AW+1)'(PROF - 1));
  assign wait_st = (state == ESPERA_JOGADA) || (state == ESPERA_NOVA);
  // A play arriving on the last idle cycle takes priority over the timeout.
  assign tmo_exp = (cnt == TMO_LAST) && !play_ev;

`ifdef JOGO_SEQ_SHOW_SEQ_EN
  logic [AW-1:0] show_idx;
  logic          show_on;
  logic          step_end;
  logic          show_done;

  assign step_end  = (cnt == TW'(ESPERA_LED - 1));
  assign show_done = step_end && !show_on && ({1'b0, show_idx} == (r - 1'b1));
  assign ram_raddr = (state == MOSTRA) ? show_idx : j;

  // Playback position: restarts every time MOSTRA is entered; each step is
  // an on half followed by an off half, advancing to the next entry after
  // the off half.
  always_ff @(posedge clock) begin
    if (reset || state != MOSTRA) begin
      show_idx <= '0;
      show_on  <= 1'b1;
    end else if (step_end) begin
      show_on <= !show_on;
      if (!show_on) show_idx <= show_idx + 1'b1;
    end
  end
`else
  assign ram_raddr = j;
`endif

  assign ram_we = (state == GRAVA) && cap_ok;

  jogo_seq_ram #(
    .DEPTH (PROF),
    .WIDTH (N_BOTOES),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (r[AW-1:0]),
    .wdata (cap),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Button register and rising-edge detector on "any button". The captured
  // value is latched on the event so COMPARA/GRAVA see it a cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      botoes_reg <= '0;
      any_prev   <= 1'b0;
      cap        <= '0;
    end else begin
      botoes_reg <= botoes;
      any_prev   <= |botoes_reg;
      if (play_ev) cap <= botoes_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= INICIAL;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      INICIAL: if (jogar) next = PREPARA;
`ifdef JOGO_SEQ_SHOW_SEQ_EN
      PREPARA: next = MOSTRA;
      MOSTRA: begin
        if (r == '0)     next = ESPERA_NOVA;
        else if (show_done) next = ESPERA_JOGADA;
      end
      PROX_RODADA: next = MOSTRA;
`else
      PREPARA:     next = ESPERA_NOVA;
      PROX_RODADA: next = ESPERA_JOGADA;
`endif
      ESPERA_JOGADA: begin
        if (play_ev)      next = COMPARA;
        else if (tmo_exp) next = TIMEOUT;
      end
      ESPERA_NOVA: begin
        if (play_ev)      next = GRAVA;
        else if (tmo_exp) next = TIMEOUT;
      end
      COMPARA:     next = (cap_ok && cap == ram_rdata) ? PROX_JOGADA : ERROU;
      PROX_JOGADA: next = j_last ? ESPERA_NOVA : ESPERA_JOGADA;
      GRAVA: begin
        if (!cap_ok)     next = ERROU;
        else if (r_last) next = ACERTOU;
        else             next = PROX_RODADA;
      end
      ACERTOU, ERROU, TIMEOUT: if (jogar) next = PREPARA;
      default: next = INICIAL;
    endcase
  end

  // Round/play counters. The final GRAVA also bumps r so db_rodada reads
  // PROF once the game is won.
  always_ff @(posedge clock) begin
    if (reset) begin
      r <= '0;
      j <= '0;
    end else begin
      case (state)
        PREPARA: begin
          r <= '0;
          j <= '0;
        end
        PROX_JOGADA: if (!j_last) j <= j + 1'b1;
        PROX_RODADA: begin
          r <= r + 1'b1;
          j <= '0;
        end
        GRAVA: if (cap_ok && r_last) r <= r + 1'b1;
        default: ;
      endcase
    end
  end

  // Shared counter: cleared on any state change; counts idle cycles in the
  // wait states (cleared by a play) and step cycles during playback.
  always_ff @(posedge clock) begin
    if (reset || next != state) begin
      cnt <= '0;
    end else if (wait_st) begin
      cnt <= play_ev ? '0 : cnt + 1'b1;
`ifdef JOGO_SEQ_SHOW_SEQ_EN
    end else if (state == MOSTRA) begin
      cnt <= step_end ? '0 : cnt + 1'b1;
`endif
    end else begin
      cnt <= '0;
    end
  end

  always_comb begin
    leds       = '0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    pronto     = 1'b0;
    db_timeout = 1'b0;
    case (state)
      ESPERA_JOGADA, ESPERA_NOVA: leds = botoes_reg;
`ifdef JOGO_SEQ_SHOW_SEQ_EN
      MOSTRA: leds = show_on ? ram_rdata : '0;
`endif
      ACERTOU: begin
        ganhou = 1'b1;
        pronto = 1'b1;
      end
      ERROU: begin
        perdeu = 1'b1;
        pronto = 1'b1;
      end
      TIMEOUT: begin
        perdeu     = 1'b1;
        pronto     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state;
  assign db_rodada = r;
  assign db_jogada = j;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Scoreboard bench for jogo_sequencia_param (N_BOTOES=4, PROF=4,
// TIMEOUT_CICLOS=100, ESPERA_LED=5). Stimulus pushes the expected
// observation for each state the DUT settles in; a monitor pops and
// compares whenever the DUT enters a wait/final/initial state.
module tb_jogo_sequencia_param;

  localparam int N_BOTOES = 4;
  localparam int PROF     = 4;
  localparam int TMO      = 100;
  localparam int ESP      = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       jogar = 1'b0;
  logic [3:0] botoes = '0;

  logic [3:0] leds;
  logic       ganhou, perdeu, pronto, db_timeout;
  logic [3:0] db_estado;
  logic [2:0] db_rodada;
  logic [1:0] db_jogada;

  jogo_sequencia_param #(
    .N_BOTOES       (N_BOTOES),
    .PROF           (PROF),
    .TIMEOUT_CICLOS (TMO),
    .ESPERA_LED     (ESP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .jogar      (jogar),
    .botoes     (botoes),
    .leds       (leds),
    .ganhou     (ganhou),
    .perdeu     (perdeu),
    .pronto     (pronto),
    .db_timeout (db_timeout),
    .db_estado  (db_estado),
    .db_rodada  (db_rodada),
    .db_jogada  (db_jogada)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] estado;
    logic [2:0] rodada;
    logic [1:0] jogada;
    logic [3:0] leds;
    logic       ganhou;
    logic       perdeu;
    logic       pronto;
    logic       tmo;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic string fmtObs(obs_t o);
    return $sformatf("estado=%h rodada=%0d jogada=%0d leds=%b ganhou=%b perdeu=%b pronto=%b timeout=%b",
                     o.estado, o.rodada, o.jogada, o.leds, o.ganhou, o.perdeu, o.pronto, o.tmo);
  endfunction

  function automatic bit isMonitored(logic [3:0] s);
    return s inside {4'h0, 4'h2, 4'h4, 4'h9, 4'hA, 4'hB};
  endfunction

  task automatic pushExp(input logic [3:0] e, input logic [2:0] r, input logic [1:0] j,
                         input logic [3:0] l, input logic g, input logic p,
                         input logic pr, input logic t);
    obs_t o;
    o = '{estado: e, rodada: r, jogada: j, leds: l, ganhou: g, perdeu: p, pronto: pr, tmo: t};
    exp_q.push_back(o);
  endtask

  task automatic checkOutput(input string name, input obs_t act, input obs_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %s, expected %s", name, fmtObs(act), fmtObs(expv));
    end
  endtask

  task automatic checkValue(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic waitState(input logic [3:0] s, input int budget, output int waited);
    waited = 0;
    while (db_estado !== s && waited < budget) begin
      @(negedge clock);
      waited++;
    end
    if (db_estado !== s) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_state_%h: got estado=%h, expected %h within %0d cycles",
               s, db_estado, s, budget);
    end
  endtask

  task automatic waitPlay();
    int waited;
    waited = 0;
    while (!(db_estado == 4'h2 || db_estado == 4'h4) && waited < 1000) begin
      @(negedge clock);
      waited++;
    end
    if (!(db_estado == 4'h2 || db_estado == 4'h4)) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_play: got estado=%h, expected 2 or 4", db_estado);
    end
  endtask

  task automatic startGame();
    @(negedge clock);
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
  endtask

  // Press a button pattern for two cycles once the DUT is waiting for a play.
  task automatic applyStimulus(input logic [3:0] b);
    waitPlay();
    botoes = b;
    @(negedge clock);
    @(negedge clock);
    botoes = '0;
  endtask

  // Monitor: compares on every entry into a monitored state and on reset release.
  initial begin
    logic [3:0] prev_st;
    logic       prev_rst;
    obs_t       act;
    int         n;
    prev_st  = 4'h0;
    prev_rst = 1'b1;
    n        = 0;
    forever begin
      @(negedge clock);
      #1;
      if ((db_estado !== prev_st && isMonitored(db_estado)) || (prev_rst && !reset)) begin
        act = '{estado: db_estado, rodada: db_rodada, jogada: db_jogada, leds: leds,
                ganhou: ganhou, perdeu: perdeu, pronto: pronto, tmo: db_timeout};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_obs_%0d: got %s, expected nothing", n, fmtObs(act));
        end else begin
          checkOutput($sformatf("obs_%0d", n), act, exp_q.pop_front());
        end
        n++;
      end
      prev_st  = db_estado;
      prev_rst = reset;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    $display("[TB] start");
    repeat (3) @(negedge clock);
    pushExp(4'h0, 3'd0, 2'd0, 4'b0000, 0, 0, 0, 0);
    reset = 1'b0;

    // Game 1: full win
    pushExp(4'h4, 3'd0, 2'd0, 4'b0000, 0, 0, 0, 0);
    startGame();
    pushExp(4'h2, 3'd1, 2'd0, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0001);
    pushExp(4'h4, 3'd1, 2'd0, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0001);
    pushExp(4'h2, 3'd2, 2'd0, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0010);
    pushExp(4'h2, 3'd2, 2'd1, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0001);
    pushExp(4'h4, 3'd2, 2'd1, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0010);
    pushExp(4'h2, 3'd3, 2'd0, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0100);
    pushExp(4'h2, 3'd3, 2'd1, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0001);
    pushExp(4'h2, 3'd3, 2'd2, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0010);
    pushExp(4'h4, 3'd3, 2'd2, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0100);
    pushExp(4'h9, 3'd4, 2'd2, 4'b0000, 1, 0, 1, 0); applyStimulus(4'b1000);
    waitState(4'h9, 50, w);

    // Game 2: wrong repeat in round 1
    pushExp(4'h4, 3'd0, 2'd0, 4'b0000, 0, 0, 0, 0);
    startGame();
    pushExp(4'h2, 3'd1, 2'd0, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0001);
    pushExp(4'hA, 3'd1, 2'd0, 4'b0000, 0, 1, 1, 0); applyStimulus(4'b0010);
    waitState(4'hA, 50, w);

    // Game 3: inactivity timeout on the first repeat of round 1
    pushExp(4'h4, 3'd0, 2'd0, 4'b0000, 0, 0, 0, 0);
    startGame();
    pushExp(4'h2, 3'd1, 2'd0, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0001);
    waitState(4'h2, 500, w);
    pushExp(4'hB, 3'd1, 2'd0, 4'b0000, 0, 1, 1, 1);
    waitState(4'hB, 300, w);
    checkValue("timeout_cycles", w, TMO);
    pushExp(4'h4, 3'd0, 2'd0, 4'b0000, 0, 0, 0, 0);
    startGame();

    // Game 4: multi-button new play in round 0
    pushExp(4'hA, 3'd0, 2'd0, 4'b0000, 0, 1, 1, 0); applyStimulus(4'b0011);
    waitState(4'hA, 50, w);

    // Game 5: held button produces a single event
    pushExp(4'h4, 3'd0, 2'd0, 4'b0000, 0, 0, 0, 0);
    startGame();
    pushExp(4'h2, 3'd1, 2'd0, 4'b0001, 0, 0, 0, 0);
    waitPlay();
    botoes = 4'b0001;
    repeat (50) @(negedge clock);
    checkValue("hold_single_event_estado", int'(db_estado), 2);
    botoes = '0;
    repeat (2) @(negedge clock);
    pushExp(4'h4, 3'd1, 2'd0, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0001);
    pushExp(4'h2, 3'd2, 2'd0, 4'b0000, 0, 0, 0, 0); applyStimulus(4'b0010);

`ifdef JOGO_SEQ_SHOW_SEQ_EN
    waitState(4'h3, 50, w);
    for (int i = 0; i < 4 * ESP; i++) begin
      int want;
      want = (i < ESP) ? 1 : (i < 2 * ESP) ? 0 : (i < 3 * ESP) ? 2 : 0;
      if (i == 2) botoes = 4'b1111;
      if (i == 4) botoes = 4'b0000;
      checkValue($sformatf("mostra_leds_%0d", i), int'(leds), want);
      @(negedge clock);
    end
    checkValue("mostra_end_estado", int'(db_estado), 2);
`endif

    waitState(4'h2, 500, w);
    // Mid-game reset with jogar and buttons active
    pushExp(4'h0, 3'd0, 2'd0, 4'b0000, 0, 0, 0, 0);
    pushExp(4'h0, 3'd0, 2'd0, 4'b0000, 0, 0, 0, 0);
    reset  = 1'b1;
    jogar  = 1'b1;
    botoes = 4'b1111;
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b0;
    jogar  = 1'b0;
    botoes = '0;
    repeat (3) @(negedge clock);
    checkValue("after_reset_estado", int'(db_estado), 0);

    pushExp(4'h4, 3'd0, 2'd0, 4'b0000, 0, 0, 0, 0);
    startGame();
    waitState(4'h4, 20, w);

    repeat (5) @(negedge clock);
    checkValue("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
